// File: rtl/hm_sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hm_sha256_pkg
// Description : SHA-256 constants, shared types and the round/schedule helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hm_sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t bsig1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hm_sha256_if.sv
`default_nettype none
// ============================================================================
// Module      : hm_sha256_if
// Description : Block request / digest return bundle of the SHA-256 core.
// Revision    : 1.0 - initial release
// ============================================================================
interface hm_sha256_if;
  logic         start;
  logic [511:0] data;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  modport master (output start, data, input busy, done, hash_out);
  modport slave  (input start, data, output busy, done, hash_out);
endinterface
`default_nettype wire

// File: rtl/hm_sha256_round.sv
`default_nettype none
// ============================================================================
// Module      : hm_sha256_round
// Description : One combinational SHA-256 compression round.
// Revision    : 1.0 - initial release
// ============================================================================
module hm_sha256_round
  import hm_sha256_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  input  word_t e,
  input  word_t f,
  input  word_t g,
  input  word_t h,
  input  word_t kt,
  input  word_t wt,
  output word_t next_a,
  output word_t next_b,
  output word_t next_c,
  output word_t next_d,
  output word_t next_e,
  output word_t next_f,
  output word_t next_g,
  output word_t next_h
);

  word_t t1;
  word_t t2;

  assign t1     = h + bsig1(e) + ch(e, f, g) + kt + wt;
  assign t2     = bsig0(a) + maj(a, b, c);
  assign next_a = t1 + t2;
  assign next_b = a;
  assign next_c = b;
  assign next_d = c;
  assign next_e = d + t1;
  assign next_f = e;
  assign next_g = f;
  assign next_h = g;

endmodule
`default_nettype wire

// File: rtl/hm_sha256_core.sv
`default_nettype none
// ============================================================================
// Module      : hm_sha256_core
// Description : Iterative SHA-256 compression of one 512-bit block, UNROLL rounds/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module hm_sha256_core
  import hm_sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  wire logic    clk,
  input  wire logic    n_rst,
  hm_sha256_if.slave   bus
);

  state_t       state;
  state_t       state_next;
  word_t        work [0:7];
  word_t        win  [0:15];
  logic [5:0]   cnt;
  logic         done_q;
  logic [255:0] hash_q;
  logic         last_round;
  word_t        last_s [0:7];
  word_t        last_w [0:15];

  // Counter never exceeds 63; the widened sum detects the final group.
  assign last_round = (7'(cnt) + 7'(UNROLL)) == 7'd64;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    word_t in_s  [0:7];
    word_t out_s [0:7];
    word_t in_w  [0:15];
    word_t out_w [0:15];

    if (j == 0) begin : g_first
      assign in_s = work;
      assign in_w = win;
    end else begin : g_next
      assign in_s = g_round[j-1].out_s;
      assign in_w = g_round[j-1].out_w;
    end

    hm_sha256_round u_round (
      .a      (in_s[0]), .b (in_s[1]), .c (in_s[2]), .d (in_s[3]),
      .e      (in_s[4]), .f (in_s[5]), .g (in_s[6]), .h (in_s[7]),
      .kt     (K[cnt + 6'(j)]),
      .wt     (in_w[0]),
      .next_a (out_s[0]), .next_b (out_s[1]), .next_c (out_s[2]), .next_d (out_s[3]),
      .next_e (out_s[4]), .next_f (out_s[5]), .next_g (out_s[6]), .next_h (out_s[7])
    );

    always_comb begin
      for (int i = 0; i < 15; i++) out_w[i] = in_w[i+1];
      out_w[15] = ssig1(in_w[14]) + in_w[9] + ssig0(in_w[1]) + in_w[0];
    end
  end

  assign last_s = g_round[UNROLL-1].out_s;
  assign last_w = g_round[UNROLL-1].out_w;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ROUND;
      ROUND:   if (last_round) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      hash_q <= '0;
      for (int i = 0; i < 8; i++)  work[i] <= '0;
      for (int i = 0; i < 16; i++) win[i]  <= '0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 16; i++) win[i]  <= bus.data[511-32*i -: 32];
            for (int i = 0; i < 8; i++)  work[i] <= IV[i];
            cnt <= '0;
          end
        end
        ROUND: begin
          work <= last_s;
          win  <= last_w;
          cnt  <= cnt + 6'(UNROLL);
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hash_q[255-32*i -: 32] <= IV[i] + work[i];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.hash_out = hash_q;

endmodule
`default_nettype wire
